// File: rtl/drone_bldc_pwm_pkg.sv
// Shared constants for the multi-channel BLDC PWM core:
// register word addresses, CTRL/STATUS bit positions, channel limit.
package drone_bldc_pwm_pkg;

    localparam int ADDR_CTRL      = 0;
    localparam int ADDR_PERIOD    = 1;
    localparam int ADDR_WDT_LIMIT = 2;
    localparam int ADDR_STATUS    = 3;
    localparam int ADDR_DUTY0     = 4;

    localparam int CTRL_ARM_BIT      = 0;
    localparam int CTRL_TRIP_CLR_BIT = 2;

    localparam int STAT_ARMED_BIT = 0;
    localparam int STAT_TRIP_BIT  = 1;

    localparam int MAX_CH = 16;

endpackage

// File: rtl/drone_bldc_pwm_chan.sv
// One motor channel: duty shadow/active registers, optional per-period
// slew limiting, counter compare and the registered PWM output.
module drone_bldc_pwm_chan #(
    parameter int CNT_W     = 16,
    parameter int SLEW_STEP = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             duty_wr,
    input  logic [CNT_W-1:0] wr_duty,
    input  logic             load,
    input  logic             trip,
    input  logic             out_en,
    input  logic [CNT_W-1:0] cnt,
    output logic [CNT_W-1:0] duty_sh,
    output logic             pwm_o
);

    localparam logic [CNT_W-1:0] STEP = CNT_W'(SLEW_STEP);

    logic [CNT_W-1:0] duty_sh_q, duty_sh_d;
    logic [CNT_W-1:0] duty_act_q, duty_act_d;
    logic [CNT_W-1:0] diff, step;
    logic             pwm_q, pwm_d;

    // Next-state: shadow write, slew-limited load at wrap, trip forces zero
    always_comb begin
        diff = (duty_sh_q > duty_act_q) ? duty_sh_q - duty_act_q
                                        : duty_act_q - duty_sh_q;
        step = (SLEW_STEP != 0 && diff > STEP) ? STEP : diff;
        duty_sh_d  = duty_sh_q;
        duty_act_d = duty_act_q;
        if (duty_wr) begin
            duty_sh_d = wr_duty;
        end
        if (load) begin
            duty_act_d = (duty_sh_q > duty_act_q) ? duty_act_q + step
                                                  : duty_act_q - step;
        end
        if (trip) begin
            duty_sh_d  = '0;
            duty_act_d = '0;
        end
        pwm_d = out_en & (cnt < duty_act_q);
    end

    // Channel state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            duty_sh_q  <= '0;
            duty_act_q <= '0;
            pwm_q      <= 1'b0;
        end else begin
            duty_sh_q  <= duty_sh_d;
            duty_act_q <= duty_act_d;
            pwm_q      <= pwm_d;
        end
    end

    assign duty_sh = duty_sh_q;
    assign pwm_o   = pwm_q;

endmodule

// File: rtl/drone_bldc_pwm_multi.sv
// Multi-channel BLDC ESC PWM core: shared period counter, shadowed
// period, watchdog, arm/trip control and the register read port.
module drone_bldc_pwm_multi
    import drone_bldc_pwm_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int CNT_W     = 16,
    parameter int WDT_W     = 24,
    parameter int ADDR_W    = 5,
    parameter int SLEW_STEP = 0
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [31:0]       wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [31:0]       rd_data,
    output logic              rd_valid,
    output logic [NUM_CH-1:0] pwm_o,
    output logic              armed_o,
    output logic              wdt_trip_o,
    output logic              period_o
);

    localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(ADDR_CTRL);
    localparam logic [ADDR_W-1:0] A_PERIOD = ADDR_W'(ADDR_PERIOD);
    localparam logic [ADDR_W-1:0] A_WDT    = ADDR_W'(ADDR_WDT_LIMIT);
    localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(ADDR_STATUS);
    localparam logic [ADDR_W-1:0] A_DUTY0  = ADDR_W'(ADDR_DUTY0);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  period_sh_q, period_sh_d;
    logic [CNT_W-1:0]  period_act_q, period_act_d;
    logic [WDT_W-1:0]  wdt_limit_q, wdt_limit_d;
    logic [WDT_W-1:0]  wdt_q, wdt_d;
    logic              armed_q, armed_d;
    logic              trip_q, trip_d;
    logic [31:0]       rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;

    logic              period_zero, load, trip_fire, ctrl_wr, out_en;
    logic [NUM_CH-1:0] duty_wr;
    logic [CNT_W-1:0]  duty_sh [NUM_CH];
    logic              unused_wr;

    assign unused_wr = ^wr_data;

    assign period_zero = (period_act_q == '0);
    assign load = period_zero || (cnt_q == period_act_q - CNT_W'(1));
    assign trip_fire = armed_q && (wdt_limit_q != '0) && (wdt_q == wdt_limit_q);
    assign ctrl_wr = wr_en && (wr_addr == A_CTRL);
    assign out_en = armed_d && !period_zero;

    // Per-channel DUTY write strobes
    always_comb begin
        duty_wr = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            duty_wr[c] = wr_en && (wr_addr == A_DUTY0 + ADDR_W'(c));
        end
    end

    // Counter, period shadow, watchdog and arm/trip next-state
    always_comb begin
        cnt_d        = load ? '0 : cnt_q + CNT_W'(1);
        period_act_d = load ? period_sh_q : period_act_q;
        period_sh_d  = period_sh_q;
        wdt_limit_d  = wdt_limit_q;
        if (wr_en && wr_addr == A_PERIOD) begin
            period_sh_d = wr_data[CNT_W-1:0];
        end
        if (wr_en && wr_addr == A_WDT) begin
            wdt_limit_d = wr_data[WDT_W-1:0];
        end
        trip_d  = trip_q;
        armed_d = armed_q;
        if (ctrl_wr) begin
            if (wr_data[CTRL_TRIP_CLR_BIT]) begin
                trip_d = 1'b0;
            end
            armed_d = wr_data[CTRL_ARM_BIT] & ~trip_d;
        end
        if (trip_fire) begin
            trip_d  = 1'b1;
            armed_d = 1'b0;
        end
        if (!armed_q || wdt_limit_q == '0 || trip_fire || |duty_wr) begin
            wdt_d = '0;
        end else begin
            wdt_d = wdt_q + WDT_W'(1);
        end
    end

    // Register read mux, registered one cycle after rd_en
    always_comb begin
        rd_data_d  = '0;
        rd_valid_d = rd_en;
        if (rd_en) begin
            case (rd_addr)
                A_CTRL:   rd_data_d[STAT_ARMED_BIT] = armed_q;
                A_PERIOD: rd_data_d = 32'(period_sh_q);
                A_WDT:    rd_data_d = 32'(wdt_limit_q);
                A_STATUS: begin
                    rd_data_d[STAT_ARMED_BIT] = armed_q;
                    rd_data_d[STAT_TRIP_BIT]  = trip_q;
                end
                default: begin
                    for (int c = 0; c < NUM_CH; c++) begin
                        if (rd_addr == A_DUTY0 + ADDR_W'(c)) begin
                            rd_data_d = 32'(duty_sh[c]);
                        end
                    end
                end
            endcase
        end
    end

    // Control-path state registers
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            cnt_q        <= '0;
            period_sh_q  <= '0;
            period_act_q <= '0;
            wdt_limit_q  <= '0;
            wdt_q        <= '0;
            armed_q      <= 1'b0;
            trip_q       <= 1'b0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            period_sh_q  <= period_sh_d;
            period_act_q <= period_act_d;
            wdt_limit_q  <= wdt_limit_d;
            wdt_q        <= wdt_d;
            armed_q      <= armed_d;
            trip_q       <= trip_d;
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_valid_d;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        drone_bldc_pwm_chan #(
            .CNT_W     (CNT_W),
            .SLEW_STEP (SLEW_STEP)
        ) u_chan (
            .clk     (ACLK),
            .rst     (ARESET),
            .duty_wr (duty_wr[g]),
            .wr_duty (wr_data[CNT_W-1:0]),
            .load    (load),
            .trip    (trip_fire),
            .out_en  (out_en),
            .cnt     (cnt_q),
            .duty_sh (duty_sh[g]),
            .pwm_o   (pwm_o[g])
        );
    end

    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
    assign armed_o    = armed_q;
    assign wdt_trip_o = trip_q;
    assign period_o   = (cnt_q == '0) && !period_zero;

endmodule

// File: tb/tb_drone_bldc_pwm_multi.sv
// Directed bench for drone_bldc_pwm_multi: an unlimited-slew instance
// and a SLEW_STEP=10 instance share the register-port stimulus.
module tb_drone_bldc_pwm_multi;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic        wr_en = 1'b0;
    logic [4:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        rd_en = 1'b0;
    logic [4:0]  rd_addr = '0;

    logic [31:0] rd_data, rd_data_s;
    logic        rd_valid, rd_valid_s;
    logic [3:0]  pwm, pwm_s;
    logic        armed, armed_s, trip, trip_s, per, per_s;

    int errors = 0;
    int checks = 0;

    always #5 ACLK = ~ACLK;

    drone_bldc_pwm_multi dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .pwm_o(pwm), .armed_o(armed),
        .wdt_trip_o(trip), .period_o(per)
    );

    drone_bldc_pwm_multi #(.SLEW_STEP(10)) dut_s (
        .ACLK(ACLK), .ARESET(ARESET),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data_s), .rd_valid(rd_valid_s),
        .pwm_o(pwm_s), .armed_o(armed_s),
        .wdt_trip_o(trip_s), .period_o(per_s)
    );

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        @(negedge ACLK);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge ACLK);
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d,
                      output logic v);
        @(negedge ACLK);
        rd_en = 1'b1; rd_addr = a;
        @(negedge ACLK);
        rd_en = 1'b0;
        d = rd_data; v = rd_valid;
    endtask

    task automatic wait_period(input int limit);
        int n = 0;
        do begin
            @(negedge ACLK);
            n++;
        end while (!per && n < limit);
        checks++;
        if (per !== 1'b1) begin
            errors++;
            $display("FAIL wait_period: period_o not seen within %0d cycles", limit);
        end
    endtask

    // Starts on a period_o negedge, runs to the next one. Optional
    // mid-period write on sample 10. Samples reflect cnt one cycle back.
    task automatic measure(input bit sel, input bit do_wr,
                           input logic [4:0] a, input logic [31:0] d,
                           output int highs, output int plen,
                           output logic first, output logic last);
        logic p;
        highs = 0; plen = 0; first = 1'b0; last = 1'b0;
        do begin
            @(negedge ACLK);
            plen++;
            if (do_wr && plen == 10) begin
                wr_en = 1'b1; wr_addr = a; wr_data = d;
            end else begin
                wr_en = 1'b0;
            end
            p = sel ? pwm_s[0] : pwm[0];
            if (plen == 1) first = p;
            last = p;
            if (p === 1'b1) highs++;
        end while (!per && plen < 1000);
        wr_en = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic v;
        repeat (2) @(negedge ACLK);
        checks++;
        if ({pwm, armed, trip, per} !== 7'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b want 0", {pwm, armed, trip, per});
        end
        ARESET = 1'b0;
        for (int r = 0; r < 8; r++) begin
            rd(5'(r), d, v);
            checks++;
            if (d !== 32'h0 || v !== 1'b1) begin
                errors++;
                $display("FAIL reset_read reg%0d: got %h valid %b want 0 valid 1", r, d, v);
            end
        end
    endtask

    task automatic test_pwm_basic();
        logic [31:0] d;
        logic v, f, l;
        int h, p;
        wr(5'd1, 32'd100);
        wr(5'd4, 32'd25);
        wr(5'd0, 32'd1);
        checks++;
        if (armed !== 1'b1) begin
            errors++;
            $display("FAIL arm: armed_o=%b want 1", armed);
        end
        rd(5'd3, d, v);
        checks++;
        if (d !== 32'h1) begin
            errors++;
            $display("FAIL status_armed: got %h want 1", d);
        end
        wait_period(300);
        wait_period(300);
        measure(1'b0, 1'b0, 5'd0, 32'd0, h, p, f, l);
        checks++;
        if (h != 25 || p != 100) begin
            errors++;
            $display("FAIL basic_duty: high=%0d period=%0d want 25/100", h, p);
        end
        checks++;
        if (f !== 1'b1 || l !== 1'b0) begin
            errors++;
            $display("FAIL basic_edge: first=%b last=%b want 1/0", f, l);
        end
        checks++;
        if (pwm[3:1] !== 3'b0) begin
            errors++;
            $display("FAIL idle_channels: got %b want 000", pwm[3:1]);
        end
    endtask

    task automatic test_shadow();
        int h, p;
        logic f, l;
        int wv[4] = '{75, 0, 150, 0};
        bit dw[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        int eh[4] = '{25, 75, 0, 100};
        for (int i = 0; i < 4; i++) begin
            measure(1'b0, dw[i], 5'd4, 32'(wv[i]), h, p, f, l);
            checks++;
            if (h != eh[i] || p != 100) begin
                errors++;
                $display("FAIL shadow_%0d: high=%0d period=%0d want %0d/100", i, h, p, eh[i]);
            end
        end
    endtask

    task automatic test_disarm();
        wr(5'd0, 32'd0);
        checks++;
        if (pwm[0] !== 1'b0 || armed !== 1'b0) begin
            errors++;
            $display("FAIL disarm: pwm=%b armed=%b want 0/0", pwm[0], armed);
        end
        wait_period(110);
    endtask

    task automatic test_slew();
        int h, p;
        logic f, l;
        int exp_h[9] = '{0, 10, 20, 30, 35, 25, 15, 5, 0};
        ARESET = 1'b1;
        @(negedge ACLK);
        ARESET = 1'b0;
        wr(5'd1, 32'd100);
        wr(5'd0, 32'd1);
        wait_period(300);
        wait_period(300);
        for (int i = 0; i < 9; i++) begin
            measure(1'b1, (i == 0 || i == 4), 5'd4,
                    (i == 0) ? 32'd35 : 32'd0, h, p, f, l);
            checks++;
            if (h != exp_h[i]) begin
                errors++;
                $display("FAIL slew_%0d: high=%0d want %0d", i, h, exp_h[i]);
            end
        end
    endtask

    task automatic test_watchdog();
        logic [31:0] d;
        logic v;
        int k = 0;
        ARESET = 1'b1;
        @(negedge ACLK);
        ARESET = 1'b0;
        wr(5'd2, 32'd500);
        wr(5'd1, 32'd100);
        wr(5'd4, 32'd150);
        wr(5'd0, 32'd1);
        do begin
            @(negedge ACLK);
            k++;
        end while (!trip && k < 2000);
        // arm edge, then 500 increments, then the trip edge
        checks++;
        if (k != 501) begin
            errors++;
            $display("FAIL wdt_time: tripped after %0d cycles want 501", k);
        end
        checks++;
        if (armed !== 1'b0 || pwm !== 4'b0) begin
            errors++;
            $display("FAIL wdt_off: armed=%b pwm=%b want 0/0000", armed, pwm);
        end
        rd(5'd3, d, v);
        checks++;
        if (d !== 32'h2) begin
            errors++;
            $display("FAIL wdt_status: got %h want 2", d);
        end
        rd(5'd4, d, v);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL wdt_duty_cleared: got %h want 0", d);
        end
        wr(5'd0, 32'd1);
        checks++;
        if (armed !== 1'b0) begin
            errors++;
            $display("FAIL arm_blocked: armed=%b want 0", armed);
        end
        wr(5'd0, 32'd5);
        checks++;
        if (armed !== 1'b1 || trip !== 1'b0) begin
            errors++;
            $display("FAIL trip_clr_arm: armed=%b trip=%b want 1/0", armed, trip);
        end
    endtask

    task automatic test_wdt_feed();
        int bad = 0;
        for (int i = 0; i < 25; i++) begin
            wr(5'd4, 32'd60);
            repeat (398) begin
                @(negedge ACLK);
                if (trip !== 1'b0) bad++;
            end
        end
        checks++;
        if (bad != 0 || armed !== 1'b1) begin
            errors++;
            $display("FAIL wdt_feed: trip cycles=%0d armed=%b want 0/1", bad, armed);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        logic v;
        int n = 0;
        do begin
            @(negedge ACLK);
            n++;
        end while (pwm[0] !== 1'b1 && n < 300);
        checks++;
        if (pwm[0] !== 1'b1) begin
            errors++;
            $display("FAIL mid_pwm_high: pwm=%b want 1", pwm[0]);
        end
        #2;
        ARESET = 1'b1;
        #1;
        checks++;
        if ({pwm, armed, trip} !== 6'b0) begin
            errors++;
            $display("FAIL mid_reset: got %b want 0", {pwm, armed, trip});
        end
        @(negedge ACLK);
        ARESET = 1'b0;
        for (int r = 0; r < 8; r++) begin
            rd(5'(r), d, v);
            checks++;
            if (d !== 32'h0) begin
                errors++;
                $display("FAIL post_reset_read reg%0d: got %h want 0", r, d);
            end
        end
    endtask

    initial begin
        test_reset();
        test_pwm_basic();
        test_shadow();
        test_disarm();
        test_slew();
        test_watchdog();
        test_wdt_feed();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
